// File: rtl/sbox_layer_iter.sv
// Iterative PRESENT S-box layer: one shared 4-bit S-box substitutes the
// 4N-bit state one nibble per cycle, with a four-phase req/ack handshake.

module sbox (
   input  logic [3:0] nib_i,
   output logic [3:0] sub_o
);

   always_comb begin
      sub_o = 4'h0;
      case (nib_i)
         4'h0: sub_o = 4'hC;
         4'h1: sub_o = 4'h5;
         4'h2: sub_o = 4'h6;
         4'h3: sub_o = 4'hB;
         4'h4: sub_o = 4'h9;
         4'h5: sub_o = 4'h0;
         4'h6: sub_o = 4'hA;
         4'h7: sub_o = 4'hD;
         4'h8: sub_o = 4'h3;
         4'h9: sub_o = 4'hE;
         4'hA: sub_o = 4'hF;
         4'hB: sub_o = 4'h8;
         4'hC: sub_o = 4'h4;
         4'hD: sub_o = 4'h7;
         4'hE: sub_o = 4'h1;
         4'hF: sub_o = 4'h2;
         default: sub_o = 4'h0;
      endcase
   end

endmodule

module sbox_layer_iter #(
   parameter int N = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req,
   output logic           ack,
   input  logic [4*N-1:0] x,
   output logic [4*N-1:0] r
);

   localparam int CntW = $clog2(N);
   localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [4*N-1:0]  data_q, data_d;
   logic [3:0]      sboxIn, sboxOut;
   logic            lastNib;

   assign sboxIn  = data_q[{cnt_q, 2'b00} +: 4];
   assign lastNib = (cnt_q == LastCnt);

   sbox uSbox (
      .nib_i (sboxIn),
      .sub_o (sboxOut)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   // Once BUSY, the request line is ignored until the last nibble is written.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req)     state_d = BUSY;
         BUSY:    if (lastNib) state_d = DONE;
         DONE:    if (!req)    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      data_d = data_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               data_d = x;
               cnt_d  = '0;
            end
         end
         BUSY: begin
            data_d[{cnt_q, 2'b00} +: 4] = sboxOut;
            cnt_d = lastNib ? '0 : cnt_q + CntW'(1);
         end
         default: ;
      endcase
   end

   always_comb begin
      ack = (state_q == DONE);
      r   = data_q;
   end

endmodule

// File: tb/tb_sbox_layer_iter.sv
// Directed self-checking bench for sbox_layer_iter with N=16 and
// hand-computed PRESENT S-box results.

module tb_sbox_layer_iter;

   localparam int N = 16;

   localparam logic [63:0] VecOrd     = 64'h0123456789ABCDEF;
   localparam logic [63:0] ResOrd     = 64'hC56B90AD3EF84712;
   localparam logic [63:0] ResOrdNib0 = 64'h0123456789ABCDE2;
   localparam logic [63:0] ResZero    = 64'hCCCCCCCCCCCCCCCC;
   localparam logic [63:0] VecOnes    = 64'hFFFFFFFFFFFFFFFF;
   localparam logic [63:0] ResOnes    = 64'h2222222222222222;

   logic           clk;
   logic           rst;
   logic           req;
   logic           ack;
   logic [4*N-1:0] x;
   logic [4*N-1:0] r;

   int testsRun;
   int testsFailed;

   sbox_layer_iter #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .req (req),
      .ack (ack),
      .x   (x),
      .r   (r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle so sampling is away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic reqVal, input logic [63:0] xVal);
      req = reqVal;
      x   = xVal;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst = 1'b1;
      applyStimulus(1'b0, 64'h0);
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset_ack", {63'b0, ack}, 64'h0);
      checkOutput("reset_r", r, 64'h0);

      // Zero vector with req held, plus latency and hold checks.
      applyStimulus(1'b1, 64'h0);
      tick();
      for (int i = 1; i < N; i++) begin
         tick();
         checkOutput($sformatf("zero_busy_ack_%0d", i), {63'b0, ack}, 64'h0);
      end
      tick();
      checkOutput("zero_ack", {63'b0, ack}, 64'h1);
      checkOutput("zero_r", r, ResZero);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput($sformatf("zero_hold_ack_%0d", i), {63'b0, ack}, 64'h1);
         checkOutput($sformatf("zero_hold_r_%0d", i), r, ResZero);
      end
      applyStimulus(1'b0, 64'h0);
      tick();
      checkOutput("zero_drop_ack", {63'b0, ack}, 64'h0);

      // Back-to-back: a single req-low cycle before the ordered request.
      applyStimulus(1'b1, VecOrd);
      tick();
      tick();
      checkOutput("ord_nib0_r", r, ResOrdNib0);
      checkOutput("ord_nib0_ack", {63'b0, ack}, 64'h0);
      for (int i = 2; i < N; i++) tick();
      checkOutput("ord_prelast_ack", {63'b0, ack}, 64'h0);
      tick();
      checkOutput("ord_ack", {63'b0, ack}, 64'h1);
      checkOutput("ord_r", r, ResOrd);
      applyStimulus(1'b0, VecOrd);
      tick();
      checkOutput("ord_drop_ack", {63'b0, ack}, 64'h0);

      // Early req drop, with x changed after capture.
      applyStimulus(1'b1, VecOnes);
      tick();
      applyStimulus(1'b0, 64'h0);
      for (int i = 1; i < N; i++) tick();
      checkOutput("early_busy_ack", {63'b0, ack}, 64'h0);
      tick();
      checkOutput("early_ack", {63'b0, ack}, 64'h1);
      checkOutput("early_r", r, ResOnes);
      tick();
      checkOutput("early_ack_pulse", {63'b0, ack}, 64'h0);
      checkOutput("early_idle_r", r, ResOnes);

      // Reset in the middle of a computation (cnt=5).
      applyStimulus(1'b1, VecOrd);
      tick();
      applyStimulus(1'b0, VecOrd);
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("midrst_ack", {63'b0, ack}, 64'h0);
      checkOutput("midrst_r", r, 64'h0);
      for (int i = 0; i < N + 2; i++) tick();
      checkOutput("midrst_idle_ack", {63'b0, ack}, 64'h0);
      checkOutput("midrst_idle_r", r, 64'h0);
      applyStimulus(1'b1, 64'h0);
      tick();
      for (int i = 0; i < N; i++) tick();
      checkOutput("postrst_ack", {63'b0, ack}, 64'h1);
      checkOutput("postrst_r", r, ResZero);
      applyStimulus(1'b0, 64'h0);
      tick();
      checkOutput("postrst_drop_ack", {63'b0, ack}, 64'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
